// File: rtl/aes_sched_pkg.sv
// Shared types and defaults for the aes_core scheduler.
package aes_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StResp
    } state_e;

    // Default ce pulse length and run timeout, in clk cycles
    localparam int unsigned DefCeHold  = 32;
    localparam int unsigned DefTimeout = 4096;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
// The pointer register lives in the caller.
module rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic           advance,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);

    logic [IDW:0] slot;
    logic         found;

    // Scan N slots starting at ptr; the first pending one wins when advance is high
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        slot      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            slot = {1'b0, ptr} + (IDW+1)'(i);
            if (slot >= (IDW+1)'(N)) begin
                slot = slot - (IDW+1)'(N);
            end
            if (advance && !found && req[slot[IDW-1:0]]) begin
                found                  = 1'b1;
                grant[slot[IDW-1:0]]   = 1'b1;
                grant_idx              = slot[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/aes_core_scheduler.sv
// Shares one aes_core between N_REQ requesters: round-robin grant, ce pulse sequencing,
// done capture with stale-done protection, and a run timeout that reports a hung core.
module aes_core_scheduler
    import aes_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned K       = 128,
    parameter int unsigned CE_HOLD = DefCeHold,
    parameter int unsigned TIMEOUT = DefTimeout,
    parameter int unsigned IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*K-1:0]   req_key,
    input  logic [N_REQ*128-1:0] req_text,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [127:0]         resp_text,
    output logic                 resp_error,
    output logic                 busy,
    output logic                 core_ce,
    output logic [K-1:0]         core_key,
    output logic [127:0]         core_plaintext,
    input  logic                 core_done,
    input  logic [127:0]         core_cyphertext
);

    localparam int unsigned MaxCnt = (CE_HOLD > TIMEOUT) ? CE_HOLD : TIMEOUT;
    localparam int unsigned CW     = $clog2(MaxCnt) + 1;

    state_e           state;
    logic [IDW-1:0]   ptr;
    logic [CW-1:0]    cnt;
    logic             armed;
    logic             done_meta;
    logic             done_s;
    logic             arb_advance;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic [K-1:0]     sel_key;
    logic [127:0]     sel_text;

    assign arb_advance = (state == StIdle);

    rr_arbiter #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_arb (
        .req       (req_valid),
        .advance   (arb_advance),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // One-hot AND-OR mux of the granted slot's key and plaintext
    always_comb begin
        sel_key  = '0;
        sel_text = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_key  = sel_key | req_key[i*K +: K];
                sel_text = sel_text | req_text[i*128 +: 128];
            end
        end
    end

    // Two-flop synchronizer for the slow-domain done level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_meta <= 1'b0;
            done_s    <= 1'b0;
        end else begin
            done_meta <= core_done;
            done_s    <= done_meta;
        end
    end

    // Scheduler FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= StIdle;
            ptr            <= '0;
            cnt            <= '0;
            armed          <= 1'b0;
            req_ready      <= '0;
            resp_valid     <= 1'b0;
            resp_id        <= '0;
            resp_text      <= '0;
            resp_error     <= 1'b0;
            busy           <= 1'b0;
            core_ce        <= 1'b0;
            core_key       <= '0;
            core_plaintext <= '0;
        end else begin
            req_ready <= '0;
            unique case (state)
                StIdle: begin
                    if (|grant) begin
                        req_ready      <= grant;
                        core_key       <= sel_key;
                        core_plaintext <= sel_text;
                        resp_id        <= grant_idx;
                        ptr            <= (grant_idx == IDW'(N_REQ - 1)) ? '0
                                                                         : grant_idx + 1'b1;
                        cnt            <= '0;
                        armed          <= 1'b0;
                        core_ce        <= 1'b1;
                        busy           <= 1'b1;
                        state          <= StLoad;
                    end
                end
                StLoad: begin
                    // A done level seen low here proves it belongs to this operation
                    if (!done_s) begin
                        armed <= 1'b1;
                    end
                    if (cnt == CW'(CE_HOLD - 1)) begin
                        core_ce <= 1'b0;
                        cnt     <= '0;
                        state   <= StRun;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StRun: begin
                    if (done_s && armed) begin
                        resp_text  <= core_cyphertext;
                        resp_error <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= StResp;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        resp_text  <= '0;
                        resp_error <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= StResp;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (!done_s) begin
                            armed <= 1'b1;
                        end
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed bench for aes_core_scheduler with a behavioural aes_core timing model.
module tb_aes_core_scheduler;

    localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Stale   = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [511:0] req_key;
    logic [511:0] req_text;
    logic [3:0]   req_ready;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [1:0]   resp_id;
    logic [127:0] resp_text;
    logic         resp_error;
    logic         busy;
    logic         core_ce;
    logic [127:0] core_key;
    logic [127:0] core_plaintext;
    logic         core_done = 1'b0;
    logic [127:0] core_cyphertext = '0;

    logic [127:0] slot_key [4];
    logic [127:0] slot_text[4];

    int checks = 0;
    int errors = 0;
    int ready_pulses, ce_cycles, run_cycles, lat;

    // core model: 0 = done 200 clk after ce falls, 1 = never done, 2 = stale done
    int   cm_mode = 0;
    logic cm_active = 1'b0;
    int   cm_cnt = 0;

    typedef struct {
        logic [3:0]   mask;
        int           exp_id;
        logic [127:0] exp_text;
    } vec_t;
    vec_t vecs[12];

    aes_core_scheduler #(
        .N_REQ   (4),
        .K       (128),
        .CE_HOLD (32),
        .TIMEOUT (4096)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_key         (req_key),
        .req_text        (req_text),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_id         (resp_id),
        .resp_text       (resp_text),
        .resp_error      (resp_error),
        .busy            (busy),
        .core_ce         (core_ce),
        .core_key        (core_key),
        .core_plaintext  (core_plaintext),
        .core_done       (core_done),
        .core_cyphertext (core_cyphertext)
    );

    always #5 clk = ~clk;

    // Pack per-slot key/text into the flat request buses
    always_comb begin
        req_key  = '0;
        req_text = '0;
        for (int i = 0; i < 4; i++) begin
            req_key[i*128 +: 128]  = slot_key[i];
            req_text[i*128 +: 128] = slot_text[i];
        end
    end

    function automatic logic [127:0] ct_model(input logic [127:0] k, input logic [127:0] t);
        if (k == FipsKey && t == FipsPt) return FipsCt;
        return k ^ {t[63:0], t[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    // aes_core timing model
    always @(posedge clk) begin
        if (core_ce) begin
            cm_active <= 1'b1;
            cm_cnt    <= 0;
            if (cm_mode == 2) begin
                core_done       <= 1'b1;
                core_cyphertext <= Stale;
            end else begin
                core_done <= 1'b0;
            end
        end else if (cm_active) begin
            cm_cnt <= cm_cnt + 1;
            if (cm_mode == 0 && cm_cnt == 199) begin
                core_done       <= 1'b1;
                core_cyphertext <= ct_model(core_key, core_plaintext);
            end
            if (cm_mode == 2 && cm_cnt == 10) core_done <= 1'b0;
            if (cm_mode == 2 && cm_cnt == 60) begin
                core_done       <= 1'b1;
                core_cyphertext <= ct_model(core_key, core_plaintext);
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction; optionally hold resp_ready low for 'hold' cycles with 'pend' requests
    task automatic run_txn(input string name, input logic [3:0] mask, input int exp_id,
                           input logic exp_err, input logic [127:0] exp_text,
                           input int hold, input logic [3:0] pend);
        logic [3:0]   gnt;
        logic [127:0] snap_text;
        logic [1:0]   snap_id;
        logic         snap_err;
        bit           got, seen_ce;
        gnt = '0; got = 0; seen_ce = 0;
        ready_pulses = 0; ce_cycles = 0; run_cycles = 0; lat = 0;
        @(negedge clk);
        req_valid = mask;
        while (!got && lat < 6000) begin
            @(posedge clk);
            #1;
            lat++;
            if (req_ready != 0) begin
                ready_pulses++;
                if (gnt == 0) gnt = req_ready;
                req_valid = '0;
            end
            if (core_ce) begin
                ce_cycles++;
                seen_ce = 1;
            end else if (seen_ce) begin
                run_cycles++;
            end
            if (resp_valid) got = 1;
        end
        req_valid = '0;
        check({name, "_resp_seen"}, 128'(got), 128'(1));
        check({name, "_grant"}, 128'(gnt), 128'(4'b0001 << exp_id));
        check({name, "_ready_pulses"}, 128'(ready_pulses), 128'(1));
        check({name, "_id"}, 128'(resp_id), 128'(exp_id));
        check({name, "_text"}, resp_text, exp_text);
        check({name, "_err"}, 128'(resp_error), 128'(exp_err));
        check({name, "_busy"}, 128'(busy), 128'(1));
        if (hold > 0) begin
            req_valid = pend;
            snap_text = resp_text;
            snap_id   = resp_id;
            snap_err  = resp_error;
            for (int c = 0; c < hold; c++) begin
                @(posedge clk);
                #1;
                check({name, "_hold_ctl"}, 128'({resp_valid, req_ready, busy, resp_id, resp_error}),
                      128'({1'b1, 4'b0000, 1'b1, snap_id, snap_err}));
                check({name, "_hold_text"}, resp_text, snap_text);
            end
            req_valid = '0;
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({name, "_accept"}, 128'({resp_valid, busy}), 128'(0));
    endtask

    initial begin
        bit seen;
        int n;

        slot_key[0]  = 128'h11111111222222223333333344444444;
        slot_text[0] = 128'h0123456789abcdef0123456789abcdef;
        slot_key[1]  = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
        slot_text[1] = 128'hfedcba9876543210fedcba9876543210;
        slot_key[2]  = FipsKey;
        slot_text[2] = FipsPt;
        slot_key[3]  = 128'hcafef00dcafef00dcafef00dcafef00d;
        slot_text[3] = 128'h00000000ffffffff00000000ffffffff;

        for (int i = 0; i < 8; i++) begin
            vecs[i].mask   = 4'b1111;
            vecs[i].exp_id = i % 4;
        end
        vecs[8].mask  = 4'b1010; vecs[8].exp_id  = 1;
        vecs[9].mask  = 4'b1010; vecs[9].exp_id  = 3;
        vecs[10].mask = 4'b0001; vecs[10].exp_id = 0;
        vecs[11].mask = 4'b0110; vecs[11].exp_id = 1;
        for (int i = 0; i < 12; i++) begin
            vecs[i].exp_text = ct_model(slot_key[vecs[i].exp_id], slot_text[vecs[i].exp_id]);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", 128'({req_ready, resp_valid, resp_id, resp_error, busy, core_ce}), 128'(0));
        check("rst_key", core_key, '0);
        check("rst_pt", core_plaintext, '0);
        check("rst_text", resp_text, '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ctl", 128'({req_ready, resp_valid, busy, core_ce}), 128'(0));

        // FIPS-197 vector on slot 2
        run_txn("fips", 4'b0100, 2, 1'b0, FipsCt, 0, 4'b0000);
        check("fips_ce_cycles", 128'(ce_cycles), 128'(32));
        check("fips_key_held", core_key, FipsKey);
        check("fips_pt_held", core_plaintext, FipsPt);

        // Round-robin table starting from pointer 0
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("rr%0d", i), vecs[i].mask, vecs[i].exp_id, 1'b0,
                    vecs[i].exp_text, 0, 4'b0000);
        end

        // Hung core: timeout error, then a normal request
        cm_mode = 1;
        run_txn("timeout", 4'b1000, 3, 1'b1, '0, 0, 4'b0000);
        check("timeout_lat", 128'(lat >= 4129 && lat <= 4131), 128'(1));
        cm_mode = 0;
        run_txn("after_to", 4'b0100, 2, 1'b0, FipsCt, 0, 4'b0000);

        // Back-pressure: 50 cycles with resp_ready low and other requests pending
        run_txn("bp", 4'b0010, 1, 1'b0, ct_model(slot_key[1], slot_text[1]), 50, 4'b1101);

        // Stale done: high through LOAD, drops in RUN, captured only on the second rise
        cm_mode = 2;
        run_txn("stale", 4'b0001, 0, 1'b0, ct_model(slot_key[0], slot_text[0]), 0, 4'b0000);
        check("stale_wait", 128'(run_cycles >= 60), 128'(1));
        cm_mode = 0;

        // Reset in the middle of RUN
        @(negedge clk);
        req_valid = 4'b0100;
        seen = 0;
        n = 0;
        while (!seen && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if (req_ready != 0) seen = 1;
        end
        req_valid = '0;
        check("mid_grant", 128'(seen), 128'(1));
        seen = 0;
        n = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (!core_ce && busy) seen = 1;
        end
        check("mid_in_run", 128'(seen), 128'(1));
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_ctl", 128'({req_ready, resp_valid, resp_id, resp_error, busy, core_ce}),
              128'(0));
        check("mid_rst_key", core_key, '0);
        check("mid_rst_pt", core_plaintext, '0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (resp_valid || busy) seen = 1;
        end
        check("mid_no_resp", 128'(seen), 128'(0));
        run_txn("post_rst", 4'b1111, 0, 1'b0, ct_model(slot_key[0], slot_text[0]), 0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
